cc_seq: RTL and testbench

- Sequential, parametrised successor of the 4-input combinational sort/reduce-mean/arithmetic calculator.
- Accepts N signed W-bit samples serially over a valid/ready handshake and latches a 3-bit opt with the first sample.
- Optionally insertion-sorts the samples descending as they arrive, optionally subtracts the truncated mean, then evaluates one of two arithmetic formulas.
- Emits one signed result with a one-cycle out_valid pulse; sits between a sample source and a downstream consumer.

---
 rtl/cc_seq.sv | 137 +++++++++++++
 tb/tb_cc_seq.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cc_seq.sv
// Serial N-sample sort / mean-reduce / arithmetic unit.
// Frames arrive over a valid/ready handshake; one signed result per frame.
module cc_seq #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 4,
  localparam int unsigned OW = 2*W+4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_data,
  input  logic        [2:0]    opt,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_n
);
  localparam int unsigned LN = $clog2(N);
  localparam int unsigned CW = $clog2(N+1);
  localparam int unsigned SW = W+LN;
  localparam int unsigned AW = W+1;

  typedef enum logic [2:0] {IDLE, LOAD, MEAN, CALC, OUT} state_e;

  state_e               state_q, state_d;
  logic signed [W-1:0]  n_q [N];
  logic signed [W-1:0]  n_d [N];
  logic signed [W-1:0]  n_sh [N];
  logic        [CW-1:0] count_q, count_d;
  logic        [2:0]    opt_q, opt_d;
  logic signed [SW-1:0] sum_q, sum_d, sum_c;
  logic signed [AW-1:0] mean_q, mean_d;
  logic signed [SW:0]   sum_x, mag_x, shr_x, mean_x;
  logic signed [AW-1:0] a_c [N];
  logic signed [OW-1:0] ax_c [N];
  logic signed [OW-1:0] result_c;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [OW-1:0] out_n_q, out_n_d;
  logic        [N-1:0]  ge_c, gp_c;
  logic                 accept, sort_c;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    if (accept && count_q == CW'(N-1)) state_d = MEAN;
      MEAN:    state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    out_valid_d = (state_q == CALC);
    out_n_d     = (state_q == CALC) ? result_c : '0;
  end

  // Sample store: append, or stable descending insertion in the accept cycle.
  always_comb begin
    sort_c  = (state_q == IDLE) ? opt[0] : opt_q[0];
    opt_d   = (state_q == IDLE && accept) ? opt : opt_q;
    count_d = count_q;
    if (accept)             count_d = count_q + CW'(1);
    else if (state_q == MEAN) count_d = '0;
    ge_c = '0;
    for (int i = 0; i < N; i++)
      ge_c[i] = (CW'(i) < count_q) && (n_q[i] >= in_data);
    gp_c = {ge_c[N-2:0], 1'b1};
    n_sh[0] = in_data;
    for (int i = 1; i < N; i++) n_sh[i] = n_q[i-1];
    n_d = n_q;
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (!sort_c) begin
          if (CW'(i) == count_q) n_d[i] = in_data;
        end else if (!ge_c[i] && CW'(i) <= count_q) begin
          n_d[i] = gp_c[i] ? in_data : n_sh[i];
        end
      end
    end
  end

  // Sum and truncate-toward-zero mean, captured while in MEAN.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) sum_c = sum_c + SW'(n_q[i]);
    sum_d  = (state_q == MEAN) ? sum_c : sum_q;
    sum_x  = (SW+1)'(sum_d);
    mag_x  = (sum_x < 0) ? -sum_x : sum_x;
    shr_x  = mag_x >>> LN;
    mean_x = (sum_x < 0) ? -shr_x : shr_x;
    mean_d = AW'(mean_x);
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_c[i]  = opt_q[1] ? AW'(n_q[i]) - mean_q : AW'(n_q[i]);
      ax_c[i] = OW'(a_c[i]);
    end
    if (opt_q[2]) result_c = ((ax_c[1] * ax_c[0]) <<< 1) + ax_c[N-1];
    else          result_c = (ax_c[N-1] + ax_c[N-2]) * ax_c[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) n_q[i] <= '0;
      count_q     <= '0;
      opt_q       <= '0;
      sum_q       <= '0;
      mean_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
    end else begin
      for (int i = 0; i < N; i++) n_q[i] <= n_d[i];
      count_q     <= count_d;
      opt_q       <= opt_d;
      sum_q       <= sum_d;
      mean_q      <= mean_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
    end
  end
endmodule

// File: tb/tb_cc_seq.sv
// Directed bench for cc_seq at N=4, W=4 with hand-computed results.
module tb_cc_seq;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned OW = 2*W+4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_data;
  logic        [2:0]    opt;
  logic                 out_valid;
  logic signed [OW-1:0] out_n;

  int n_tests = 0;
  int n_fail  = 0;

  cc_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .opt(opt), .out_valid(out_valid), .out_n(out_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Feeds one frame (opt scrambled after the first sample) and checks the output timing.
  task automatic run_frame(input string tag, input logic [2:0] o,
                           input logic signed [W-1:0] s0, input logic signed [W-1:0] s1,
                           input logic signed [W-1:0] s2, input logic signed [W-1:0] s3,
                           input int exp, input bit gap, input bit hold);
    logic signed [W-1:0] s [4];
    s = '{s0, s1, s2, s3};
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (gap && k == 2) begin
        in_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check({tag, " gap_rdy"}, int'(in_ready), 1);
        end
      end
      in_valid = 1'b1;
      in_data  = s[k];
      opt      = (k == 0) ? o : ~o;
      @(negedge clk);
    end
    if (hold) in_data = 4'sd7;
    else      in_valid = 1'b0;
    check({tag, " mean_rdy"}, int'(in_ready), 0);
    check({tag, " mean_vld"}, int'(out_valid), 0);
    @(negedge clk);
    check({tag, " calc_vld"}, int'(out_valid), 0);
    @(negedge clk);
    check({tag, " out_vld"}, int'(out_valid), 1);
    check({tag, " out_n"}, int'(out_n), exp);
    check({tag, " out_rdy"}, int'(in_ready), 0);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, " post_vld"}, int'(out_valid), 0);
    check({tag, " post_n"}, int'(out_n), 0);
    check({tag, " post_rdy"}, int'(in_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; opt = '0;
    #12;
    check("rst_rdy", int'(in_ready), 1);
    check("rst_vld", int'(out_valid), 0);
    check("rst_n", int'(out_n), 0);
    @(negedge clk);
    rst = 1'b0;

    run_frame("plain",    3'b000,  4'sd3, -4'sd2,  4'sd5,  4'sd1, -12, 1'b0, 1'b0);
    run_frame("sort",     3'b001,  4'sd3, -4'sd2,  4'sd5,  4'sd1,  -3, 1'b0, 1'b0);
    run_frame("sortmean", 3'b011,  4'sd3, -4'sd2,  4'sd5,  4'sd1,  -6, 1'b0, 1'b0);
    run_frame("negmean",  3'b110, -4'sd8, -4'sd8, -4'sd8,  4'sd7,  43, 1'b0, 1'b0);
    run_frame("trunc0",   3'b110, -4'sd1, -4'sd1, -4'sd1,  4'sd2,   4, 1'b0, 1'b0);
    run_frame("maxprod",  3'b100, -4'sd8, -4'sd8,  4'sd0,  4'sd7, 135, 1'b0, 1'b0);
    run_frame("ties",     3'b101,  4'sd2,  4'sd2,  4'sd2,  4'sd2,  10, 1'b0, 1'b0);
    run_frame("posmean",  3'b010,  4'sd7,  4'sd7,  4'sd7,  4'sd6,   1, 1'b0, 1'b0);
    run_frame("allmin",   3'b111, -4'sd8, -4'sd8, -4'sd8, -4'sd8,   0, 1'b0, 1'b0);
    run_frame("gap",      3'b000,  4'sd3, -4'sd2,  4'sd5,  4'sd1, -12, 1'b1, 1'b0);
    run_frame("hold",     3'b001,  4'sd3, -4'sd2,  4'sd5,  4'sd1,  -3, 1'b0, 1'b1);

    // Partial frame then asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'sd3; opt = 3'b000;
    @(negedge clk);
    in_data = -4'sd2;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_rdy", int'(in_ready), 1);
    check("midrst_vld", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_idle_vld", int'(out_valid), 0);
    end
    run_frame("afterrst", 3'b001,  4'sd3, -4'sd2,  4'sd5,  4'sd1,  -3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
